mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and access sequencer between instruction fetch and the load/store path of the RV64 core. It accepts one fetch requester and one data requester (driven by the control unit's memrw/memword/memsign decode). It serialises both onto one 64-bit memory port with a valid/ack handshake. It performs store lane steering and byte strobes, load extraction with sign/zero extension, and misalignment checks.

## Interface
- ADDR_W, 64, address width of all address ports
- MAX_DBURST, 4, consecutive data grants allowed while fetch waits before fetch is forced (≥1)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch request; held stable until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  one-cycle response pulse
- if_rdata  out  32  instruction word, valid with if_ready
- if_err  out  1  misaligned fetch, valid with if_ready
- d_valid  in  1  data request; held stable until d_ready
- d_we  in  1  1 = store (memrw write), 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  64  store data, LSB-aligned
- d_word  in  2  size: 0 byte, 1 half, 2 word, 3 double
- d_memsign  in  1  1 = zero-extend load (funct3[2]), 0 = sign-extend
- d_ready  out  1  one-cycle response pulse
- d_rdata  out  64  extended load data, valid with d_ready; 0 for stores
- d_err  out  1  misaligned access, valid with d_ready
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address with [2:0] forced to 0
- mem_wdata  out  64  lane-steered store data
- mem_wstrb  out  8  byte strobes; 0 for reads
- mem_ack  in  1  memory completion; mem_rdata valid same cycle
- mem_rdata  in  64  read data

## Operation
- States: IDLE, ISSUE, DONE. Arbiter decisions are made only in IDLE.
- IDLE:
  - No valid request: stay in IDLE.
  - Only one requester valid: grant it.
  - Both valid: grant data, unless dcnt == MAX_DBURST, in which case grant fetch.
- dcnt update:
  - Data grant with if_valid high: dcnt increments.
  - Fetch grant, or data grant with if_valid low: dcnt clears.
- Alignment checks, evaluated at grant:
  - Fetch is misaligned if if_addr[1:0] != 0.
  - Data is misaligned if the address is not a multiple of 2^d_word.
- Misaligned grant: go to DONE directly, no memory access. DONE pulses the requester's ready with err=1 and rdata=0.
- Aligned grant: register request fields and go to ISSUE, with mem_req=1.
  - mem_addr = {addr[ADDR_W-1:3], 3'b0}.
  - Store: mem_wdata = d_wdata << 8*addr[2:0]; mem_wstrb = ((1<<2^d_word)-1) << addr[2:0].
  - Load/fetch: mem_we=0, mem_wstrb=0.
- ISSUE: hold all mem_* outputs stable until mem_ack. On mem_ack: deassert mem_req, capture mem_rdata, go to DONE.
- DONE: pulse the granted requester's ready for one cycle, then return to IDLE.
  - Fetch: if_rdata = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - Load: shift mem_rdata right by 8*addr[2:0], truncate to the access size, then extend: zero-extend if d_memsign=1, else sign-extend from the top bit of the size. Double loads are passed through unchanged.
- mem_ack outside ISSUE is ignored.
- The two ready signals are never high in the same cycle.

## Timing
- Reset values: state IDLE, dcnt 0. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ready, if_rdata, if_err, d_ready, d_rdata, d_err.
- Request seen in IDLE at cycle N: mem_req high at N+1.
- mem_ack at cycle M ≥ N+1: ready pulse at M+1, IDLE at M+2.
- Zero-wait memory (mem_ack at N+1) gives 2-cycle latency from request to ready. Back-to-back issue rate is one access per 3 cycles.
- Misaligned request at N: ready+err at N+1, IDLE at N+2.
- Requester may drop valid or present its next request in the cycle after its ready pulse. Dropping valid before ready is illegal and is not checked.
- rst mid-access takes priority over all else: next cycle is IDLE with all outputs 0. A stale mem_ack arriving after reset is ignored.

## Test plan
- Fetch 0x1004, mem_ack 1 cycle after mem_req, mem_rdata=0xAABBCCDD_11223344:
  - mem_addr=0x1000, if_rdata=0xAABBCCDD, if_ready 2 cycles after request.
- Load byte at 0x2003, d_memsign=0, mem_rdata byte3=0x80 → d_rdata=0xFFFFFFFFFFFFFF80. Same access with d_memsign=1 → 0x80.
- Store half at 0x2006, d_wdata=0xBEEF:
  - mem_wstrb=0xC0, mem_wdata[63:48]=0xBEEF, mem_we=1.
  - d_ready pulse with d_rdata=0.
- Both requesters held valid continuously, MAX_DBURST=4:
  - Grant order D,D,D,D,I,D,D,D,D,I.
  - Ready pulses never overlap.
- Misaligned cases, each with no mem_req:
  - Word load at 0x2002 → d_err=1, d_ready at N+1.
  - Fetch at 0x1002 → if_err=1.
- Reset during ISSUE with mem_ack 3 cycles later:
  - mem_req=0 the cycle after rst.
  - The late mem_ack produces no ready pulse.
  - The next fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one fetch and one load/store requester onto a 64-bit memory port.
// Latency: request -> mem_req next cycle; ready one cycle after mem_ack (2 cycles with zero-wait memory).
// Backpressure: requesters hold valid until their ready pulse; mem_* held stable until mem_ack.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_valid/if_addr              fetch request in; if_ready/if_rdata/if_err response out
//   d_valid/d_we/d_addr/d_wdata   data request in (d_word = size, d_memsign = zero-extend)
//   d_ready/d_rdata/d_err         data response out (d_rdata = extended load data, 0 for stores)
//   mem_req/mem_we/mem_addr       memory request out, doubleword aligned address
//   mem_wdata/mem_wstrb           lane-steered store data and byte strobes
//   mem_ack/mem_rdata             memory completion in, read data valid with ack
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int MAX_DBURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  input  logic [1:0]        d_word,
  input  logic              d_memsign,
  output logic              d_ready,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
);

  localparam int DCNT_W = $clog2(MAX_DBURST + 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(MAX_DBURST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic                sel_d_q;   // granted requester: 1 = data, 0 = fetch
  logic                we_q;
  logic [2:0]          lo_q;      // byte offset within the doubleword
  logic [1:0]          size_q;
  logic                zext_q;

  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [63:0]         mem_wdata_q;
  logic [7:0]          mem_wstrb_q;
  logic                if_ready_q;
  logic [31:0]         if_rdata_q;
  logic                if_err_q;
  logic                d_ready_q;
  logic [63:0]         d_rdata_q;
  logic                d_err_q;

  // ---------------------------------------------------------------------------
  // Arbitration: data wins ties until it has taken MAX_DBURST grants in a row
  // while fetch was waiting, then fetch is forced through once.
  // ---------------------------------------------------------------------------
  logic gnt_fetch_d;
  logic gnt_data_d;

  always_comb begin
    gnt_fetch_d = 1'b0;
    gnt_data_d  = 1'b0;
    if (if_valid && d_valid) begin
      if (dcnt_q == DCNT_MAX) begin
        gnt_fetch_d = 1'b1;
      end else begin
        gnt_data_d = 1'b1;
      end
    end else begin
      gnt_fetch_d = if_valid;
      gnt_data_d  = d_valid;
    end
  end

  // Counter only grows while fetch is actually being held off.
  logic [DCNT_W-1:0] dcnt_d;
  assign dcnt_d = (gnt_data_d && if_valid) ? dcnt_q + DCNT_W'(1) : '0;

  // ---------------------------------------------------------------------------
  // Alignment and store lane steering
  // ---------------------------------------------------------------------------
  logic [2:0] size_mask;
  logic [7:0] strb_base;

  always_comb begin
    size_mask = 3'b000;
    strb_base = 8'h01;
    case (d_word)
      2'd0: begin size_mask = 3'b000; strb_base = 8'h01; end
      2'd1: begin size_mask = 3'b001; strb_base = 8'h03; end
      2'd2: begin size_mask = 3'b011; strb_base = 8'h0F; end
      default: begin size_mask = 3'b111; strb_base = 8'hFF; end
    endcase
  end

  logic        f_mis;
  logic        d_mis;
  logic [63:0] wdata_d;
  logic [7:0]  wstrb_d;

  assign f_mis   = |if_addr[1:0];
  assign d_mis   = |(d_addr[2:0] & size_mask);
  assign wdata_d = d_wdata << {d_addr[2:0], 3'b000};
  // Aligned accesses never spill past byte 7, so the 8-bit truncation is exact.
  assign wstrb_d = strb_base << d_addr[2:0];

  // ---------------------------------------------------------------------------
  // Load extraction and extension, evaluated against the live mem_rdata so the
  // result can be registered on the mem_ack edge.
  // ---------------------------------------------------------------------------
  logic [63:0] rd_shift;
  logic [63:0] ld_data_d;
  logic [31:0] fetch_data_d;

  assign rd_shift     = mem_rdata >> {lo_q, 3'b000};
  assign fetch_data_d = lo_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];

  always_comb begin
    ld_data_d = rd_shift;
    case (size_q)
      2'd0: ld_data_d = zext_q ? {56'd0, rd_shift[7:0]}
                               : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1: ld_data_d = zext_q ? {48'd0, rd_shift[15:0]}
                               : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2: ld_data_d = zext_q ? {32'd0, rd_shift[31:0]}
                               : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: ld_data_d = rd_shift;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE decides, ISSUE waits for mem_ack, DONE pulses ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      sel_d_q     <= 1'b0;
      we_q        <= 1'b0;
      lo_q        <= 3'd0;
      size_q      <= 2'd0;
      zext_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_fetch_d || gnt_data_d) begin
            dcnt_q  <= dcnt_d;
            sel_d_q <= gnt_data_d;
            if (gnt_fetch_d) begin
              we_q   <= 1'b0;
              lo_q   <= if_addr[2:0];
              size_q <= 2'd2;
              zext_q <= 1'b1;
              if (f_mis) begin
                state_q    <= S_DONE;
                if_ready_q <= 1'b1;
                if_err_q   <= 1'b1;
                if_rdata_q <= '0;
              end else begin
                state_q     <= S_ISSUE;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= {if_addr[ADDR_W-1:3], 3'b000};
                mem_wdata_q <= '0;
                mem_wstrb_q <= '0;
              end
            end else begin
              we_q   <= d_we;
              lo_q   <= d_addr[2:0];
              size_q <= d_word;
              zext_q <= d_memsign;
              if (d_mis) begin
                state_q   <= S_DONE;
                d_ready_q <= 1'b1;
                d_err_q   <= 1'b1;
                d_rdata_q <= '0;
              end else begin
                state_q     <= S_ISSUE;
                mem_req_q   <= 1'b1;
                mem_we_q    <= d_we;
                mem_addr_q  <= {d_addr[ADDR_W-1:3], 3'b000};
                mem_wdata_q <= d_we ? wdata_d : '0;
                mem_wstrb_q <= d_we ? wstrb_d : '0;
              end
            end
          end
        end

        S_ISSUE: begin
          if (mem_ack) begin
            state_q     <= S_DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            if (sel_d_q) begin
              d_ready_q <= 1'b1;
              d_err_q   <= 1'b0;
              d_rdata_q <= we_q ? '0 : ld_data_d;
            end else begin
              if_ready_q <= 1'b1;
              if_err_q   <= 1'b0;
              if_rdata_q <= fetch_data_d;
            end
          end
        end

        S_DONE: begin
          state_q    <= S_IDLE;
          if_ready_q <= 1'b0;
          if_err_q   <= 1'b0;
          if_rdata_q <= '0;
          d_ready_q  <= 1'b0;
          d_err_q    <= 1'b0;
          d_rdata_q  <= '0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases followed by randomized single-requester traffic.
// Reference model is a byte-addressed memory with plain load/store/fetch semantics.
// Memory responder acknowledges after a programmable number of wait cycles.
module tb_mem_arbiter;

  localparam int ADDR_W     = 64;
  localparam int MAX_DBURST = 4;

  logic              clk;
  logic              rst;
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_rdata;
  logic              if_err;
  logic              d_valid;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic [1:0]        d_word;
  logic              d_memsign;
  logic              d_ready;
  logic [63:0]       d_rdata;
  logic              d_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wstrb;
  logic              mem_ack;
  logic [63:0]       mem_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DBURST(MAX_DBURST)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_word(d_word), .d_memsign(d_memsign), .d_ready(d_ready),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory device seen by the DUT (written through mem_wstrb) and the
  // independent byte-level reference memory.
  logic [63:0] mem [32];
  logic [7:0]  ref_mem [256];
  bit          auto_mem;
  int          mem_lat;
  int          wait_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          wait_cnt  = 0;
          mem_rdata = mem[mem_addr[7:3]];
          if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
              if (mem_wstrb[b]) mem[mem_addr[7:3]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  // Wait for the selected ready; lat = cycles from request, -1 on timeout.
  task automatic wait_resp(input bit is_d, output int lat, output bit saw_req,
                           output logic [63:0] req_addr);
    lat      = -1;
    saw_req  = 1'b0;
    req_addr = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mem_req && !saw_req) begin
        saw_req  = 1'b1;
        req_addr = mem_addr;
      end
      if (is_d ? d_ready : if_ready) begin
        lat = i;
        return;
      end
    end
  endtask

  int          lat;
  bit          saw_req;
  logic [63:0] req_addr;
  byte         got [$];
  string       exp_order;
  int          kind, sz, nb, lo;
  bit          zx, bad;
  logic [63:0] a, wd, val;

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_addr = '0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_word = 2'd0; d_memsign = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    auto_mem = 1'b1; mem_lat = 0; wait_cnt = 0;
    for (int w = 0; w < 32; w++) mem[w] = '0;

    // ---- reset state ----
    tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_if_err", if_err, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_d_err", d_err, 0);
    rst = 1'b0;
    tick();

    // ---- fetch 0x1004, zero-wait memory ----
    mem[0] = 64'hAABBCCDD_11223344;
    if_valid = 1'b1; if_addr = 64'h1004;
    tick();
    check("f_mem_req", mem_req, 1);
    check("f_mem_addr", mem_addr, 64'h1000);
    check("f_mem_we", mem_we, 0);
    check("f_mem_wstrb", mem_wstrb, 0);
    tick();
    check("f_if_ready", if_ready, 1);
    check("f_if_rdata", if_rdata, 64'hAABBCCDD);
    check("f_if_err", if_err, 0);
    check("f_d_ready", d_ready, 0);
    if_valid = 1'b0;
    tick();
    check("f_if_ready_drop", if_ready, 0);

    // ---- load byte 0x2003, sign then zero extension ----
    mem[0] = 64'h12345678_80ABCDEF;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 64'h2003; d_word = 2'd0; d_memsign = 1'b0;
    wait_resp(1'b1, lat, saw_req, req_addr);
    check("lb_lat", lat, 2);
    check("lb_sext", d_rdata, 64'hFFFFFFFFFFFFFF80);
    check("lb_err", d_err, 0);
    d_valid = 1'b0;
    tick();
    d_valid = 1'b1; d_memsign = 1'b1;
    wait_resp(1'b1, lat, saw_req, req_addr);
    check("lbu_zext", d_rdata, 64'h80);
    d_valid = 1'b0;
    tick();

    // ---- store half 0x2006 ----
    d_valid = 1'b1; d_we = 1'b1; d_addr = 64'h2006; d_word = 2'd1; d_wdata = 64'hBEEF;
    tick();
    check("sh_mem_req", mem_req, 1);
    check("sh_mem_we", mem_we, 1);
    check("sh_mem_wstrb", mem_wstrb, 8'hC0);
    check("sh_mem_wdata_hi", mem_wdata[63:48], 16'hBEEF);
    tick();
    check("sh_d_ready", d_ready, 1);
    check("sh_d_rdata", d_rdata, 0);
    check("sh_mem_word", mem[0], 64'hBEEF5678_80ABCDEF);
    d_valid = 1'b0; d_we = 1'b0;
    tick();

    // ---- both requesters continuously valid ----
    exp_order = "DDDDIDDDDI";
    if_valid = 1'b1; if_addr = 64'h1000;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 64'h2000; d_word = 2'd3;
    for (int i = 0; i < 80 && got.size() < 10; i++) begin
      tick();
      check("burst_excl", if_ready & d_ready, 0);
      if (d_ready) got.push_back("D");
      if (if_ready) got.push_back("I");
    end
    if_valid = 1'b0; d_valid = 1'b0;
    check("burst_count", got.size(), 10);
    for (int i = 0; i < got.size() && i < 10; i++) begin
      check($sformatf("burst_order%0d", i), got[i], exp_order[i]);
    end
    tick();

    // ---- misaligned word load and fetch ----
    d_valid = 1'b1; d_we = 1'b0; d_addr = 64'h2002; d_word = 2'd2;
    tick();
    check("mis_d_ready", d_ready, 1);
    check("mis_d_err", d_err, 1);
    check("mis_d_rdata", d_rdata, 0);
    check("mis_d_mem_req", mem_req, 0);
    d_valid = 1'b0;
    tick();
    check("mis_d_ready_drop", d_ready, 0);
    if_valid = 1'b1; if_addr = 64'h1002;
    tick();
    check("mis_f_ready", if_ready, 1);
    check("mis_f_err", if_err, 1);
    check("mis_f_rdata", if_rdata, 0);
    check("mis_f_mem_req", mem_req, 0);
    if_valid = 1'b0;
    tick();

    // ---- reset during ISSUE, late mem_ack ----
    auto_mem = 1'b0; mem_ack = 1'b0;
    if_valid = 1'b1; if_addr = 64'h1008;
    tick();
    check("rsti_mem_req", mem_req, 1);
    rst = 1'b1;
    tick();
    check("rsti_mem_req_off", mem_req, 0);
    check("rsti_if_ready", if_ready, 0);
    rst = 1'b0; if_valid = 1'b0;
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 64'h0BAD0BAD_0BAD0BAD;
    tick();
    mem_ack = 1'b0;
    check("stale_if_ready", if_ready, 0);
    check("stale_mem_req", mem_req, 0);
    tick();
    check("stale_if_ready2", if_ready, 0);
    check("stale_d_ready2", d_ready, 0);
    auto_mem = 1'b1; wait_cnt = 0;
    mem[1] = 64'hCAFEF00D_DEADBEEF;
    if_valid = 1'b1; if_addr = 64'h1008;
    wait_resp(1'b0, lat, saw_req, req_addr);
    check("post_rst_lat", lat, 2);
    check("post_rst_rdata", if_rdata, 64'hDEADBEEF);
    check("post_rst_err", if_err, 0);
    if_valid = 1'b0;
    tick();

    // ---- randomized traffic against the byte model ----
    for (int w = 0; w < 32; w++) begin
      mem[w] = {$urandom(), $urandom()};
      for (int b = 0; b < 8; b++) ref_mem[8*w + b] = mem[w][8*b +: 8];
    end
    for (int t = 0; t < 300; t++) begin
      kind    = $urandom_range(0, 2);   // 0 fetch, 1 load, 2 store
      a       = {$urandom(), $urandom()};
      sz      = $urandom_range(0, 3);
      zx      = 1'($urandom_range(0, 1));
      wd      = {$urandom(), $urandom()};
      mem_lat = $urandom_range(0, 3);
      lo      = int'(a[7:0]);
      val     = '0;
      if (kind == 0) begin
        bad = (a % 4) != 0;
        if (!bad) for (int i = 0; i < 4; i++) val |= 64'(ref_mem[8'(lo + i)]) << (8 * i);
        if_valid = 1'b1; if_addr = a;
      end else begin
        nb  = 1 << sz;
        bad = (a % nb) != 0;
        if (!bad && kind == 1) begin
          for (int i = 0; i < nb; i++) val |= 64'(ref_mem[8'(lo + i)]) << (8 * i);
          if (!zx && sz < 3 && val[8*nb-1]) val |= ~((64'd1 << (8 * nb)) - 64'd1);
        end
        if (!bad && kind == 2) begin
          for (int i = 0; i < nb; i++) ref_mem[8'(lo + i)] = wd[8*i +: 8];
        end
        d_valid = 1'b1; d_we = (kind == 2); d_addr = a; d_word = 2'(sz);
        d_wdata = wd; d_memsign = zx;
      end
      wait_resp(kind != 0, lat, saw_req, req_addr);
      check("rnd_lat", lat, bad ? 1 : mem_lat + 2);
      check("rnd_mem_req", saw_req, !bad);
      if (!bad) check("rnd_mem_addr", req_addr, {a[63:3], 3'b000});
      if (kind == 0) begin
        check("rnd_if_rdata", if_rdata, val);
        check("rnd_if_err", if_err, bad);
        check("rnd_other_ready", d_ready, 0);
      end else begin
        check("rnd_d_rdata", d_rdata, val);
        check("rnd_d_err", d_err, bad);
        check("rnd_other_ready", if_ready, 0);
      end
      if_valid = 1'b0; d_valid = 1'b0;
      tick();
    end

    // Final readback of the device memory against the byte model.
    for (int w = 0; w < 32; w++) begin
      for (int b = 0; b < 8; b++) val[8*b +: 8] = ref_mem[8*w + b];
      check($sformatf("final_mem%0d", w), mem[w], val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
